// File: rtl/servo_pwm_pkg.sv
// Shared types and defaults for the servo PWM scheduler.
package servo_pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_st_t;

  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;
  localparam int MAX_CH     = 16;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one tick every i_div+1 enabled clocks, with synchronous clear.
module pwm_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  // >= rather than == keeps the counter bounded even if the divider ever shrinks.
  assign o_tick = i_en && (r_cnt >= i_div);

  // Count enabled clocks and wrap on the tick.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= {DIV_W{1'b0}};
    end else if (o_tick) begin
      r_cnt <= {DIV_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + DIV_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/servo_pwm_sched.sv
// Frame-aligned multi-channel servo PWM with double-buffered duty configuration.
module servo_pwm_sched
  import servo_pwm_pkg::*;
#(
  parameter int N_CH   = 12,
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic [DIV_W-1:0]  cfg_freq_div,
  input  logic              duty_wr_en,
  input  logic [3:0]        duty_wr_ch,
  input  logic [DUTY_W-1:0] duty_wr_val,
  input  logic              commit_req,
  input  logic              enable,
  output logic [N_CH-1:0]   pwm_out,
  output logic              frame_start,
  output logic              commit_ack,
  output logic              wr_err,
  output logic              busy
);

  sched_st_t         r_state;
  sched_st_t         w_state_nxt;
  logic [DIV_W-1:0]  r_shadow_div;
  logic [DUTY_W-1:0] r_period_cnt;
  logic [DUTY_W-1:0] r_pending [N_CH];
  logic [DUTY_W-1:0] r_active  [N_CH];
  logic              r_commit_flag;
  logic [N_CH-1:0]   r_pwm;
  logic [N_CH-1:0]   w_cmp;
  logic              r_frame_start;
  logic              r_commit_ack;
  logic              r_wr_err;
  logic              r_busy;
  logic              w_tick;
  logic              w_running;
  logic              w_start;
  logic              w_boundary;
  logic              w_wr_bad;

  assign w_running  = (r_state != IDLE);
  assign w_start    = (r_state == IDLE) && enable;
  // The wrap tick of the period counter is the frame boundary.
  assign w_boundary = w_tick && (r_period_cnt == {DUTY_W{1'b1}});
  assign w_wr_bad   = duty_wr_en && ({1'b0, duty_wr_ch} >= 5'(N_CH));

  pwm_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .i_clk  (s_axi_aclk),
    .i_rst  (s_axi_areset),
    .i_clr  (w_start),
    .i_en   (w_running),
    .i_div  (r_shadow_div),
    .o_tick (w_tick)
  );

  // Scheduler state register.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a stop request always lets the current frame finish.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (enable) w_state_nxt = RUN;
        else        w_state_nxt = IDLE;
      end
      RUN: begin
        if (!enable) w_state_nxt = DRAIN;
        else         w_state_nxt = RUN;
      end
      DRAIN: begin
        if (enable)          w_state_nxt = RUN;
        else if (w_boundary) w_state_nxt = IDLE;
        else                 w_state_nxt = DRAIN;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Period counter, shadow divider and commit flag; divider only reloads at run entry or a boundary.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_period_cnt  <= {DUTY_W{1'b0}};
      r_shadow_div  <= {DIV_W{1'b0}};
      r_commit_flag <= 1'b0;
    end else if (w_start) begin
      r_period_cnt  <= {DUTY_W{1'b0}};
      r_shadow_div  <= cfg_freq_div;
      r_commit_flag <= 1'b0;
    end else if (w_boundary) begin
      // A request landing on the boundary itself waits for the next one.
      r_period_cnt  <= {DUTY_W{1'b0}};
      r_shadow_div  <= cfg_freq_div;
      r_commit_flag <= commit_req;
    end else begin
      r_period_cnt  <= w_tick ? (r_period_cnt + DUTY_W'(1)) : r_period_cnt;
      r_shadow_div  <= r_shadow_div;
      r_commit_flag <= r_commit_flag | commit_req;
    end
  end

  // Pending bank takes writes; active bank copies the pre-write pending bank on entry or commit.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int i = 0; i < N_CH; i++) begin
        r_pending[i] <= {DUTY_W{1'b0}};
        r_active[i]  <= {DUTY_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (duty_wr_en && (duty_wr_ch == 4'(i))) r_pending[i] <= duty_wr_val;
        else                                      r_pending[i] <= r_pending[i];
        if (w_start || (w_boundary && r_commit_flag)) r_active[i] <= r_pending[i];
        else                                           r_active[i] <= r_active[i];
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign w_cmp[g] = w_running && (r_period_cnt < r_active[g]);
  end

  // Registered outputs; frame_start marks every frame that actually begins.
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_pwm         <= {N_CH{1'b0}};
      r_frame_start <= 1'b0;
      r_commit_ack  <= 1'b0;
      r_wr_err      <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_pwm         <= w_cmp;
      r_frame_start <= w_start || (w_boundary && (w_state_nxt != IDLE));
      r_commit_ack  <= w_boundary && r_commit_flag;
      r_wr_err      <= w_wr_bad;
      r_busy        <= (w_state_nxt != IDLE);
    end
  end

  assign pwm_out     = r_pwm;
  assign frame_start = r_frame_start;
  assign commit_ack  = r_commit_ack;
  assign wr_err      = r_wr_err;
  assign busy        = r_busy;

endmodule

// File: tb/tb_servo_pwm_sched.sv
// Scoreboard bench for servo_pwm_sched: a frame-level reference model predicts control
// outputs per cycle and each frame's length and per-channel pulse widths.
module tb_servo_pwm_sched;

  localparam int N_CH   = 12;
  localparam int DUTY_W = 8;
  localparam int DIV_W  = 8;
  localparam int FRAME_TICKS = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [DIV_W-1:0]  cfg_div;
  logic              wr_en;
  logic [3:0]        wr_ch;
  logic [DUTY_W-1:0] wr_val;
  logic              commit;
  logic              en;
  logic [N_CH-1:0]   pwm_out;
  logic              frame_start, commit_ack, wr_err, busy;

  int n_total = 0;
  int n_bad   = 0;

  servo_pwm_sched #(.N_CH(N_CH), .DUTY_W(DUTY_W), .DIV_W(DIV_W)) dut (
    .s_axi_aclk   (clk),
    .s_axi_areset (rst),
    .cfg_freq_div (cfg_div),
    .duty_wr_en   (wr_en),
    .duty_wr_ch   (wr_ch),
    .duty_wr_val  (wr_val),
    .commit_req   (commit),
    .enable       (en),
    .pwm_out      (pwm_out),
    .frame_start  (frame_start),
    .commit_ack   (commit_ack),
    .wr_err       (wr_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: mode 0=stopped, 1=running, 2=finishing last frame.
  int m_mode = 0;
  int m_pos  = 0;
  int m_len  = FRAME_TICKS;
  int m_pending [N_CH];
  int m_active  [N_CH];
  bit m_flag    = 1'b0;
  bit m_aborted = 1'b0;

  logic [4:0]           q_ctl[$];   // {busy, frame_start, commit_ack, wr_err, stopped}
  int                   q_len[$];
  logic [N_CH*16-1:0]   q_hi[$];

  // Reference model: advances one clock using the inputs sampled on this edge.
  always @(posedge clk) begin
    logic e_fs, e_ack, e_werr;
    logic [N_CH*16-1:0] hi;
    e_fs = 1'b0; e_ack = 1'b0; e_werr = 1'b0; hi = '0;
    if (rst) begin
      if (m_mode != 0) m_aborted = 1'b1;
      m_mode = 0; m_pos = 0; m_flag = 1'b0;
      for (int i = 0; i < N_CH; i++) begin m_pending[i] = 0; m_active[i] = 0; end
    end else begin
      e_werr = wr_en && (int'(wr_ch) >= N_CH);
      if (m_mode == 0) begin
        if (en) begin
          m_mode = 1; m_pos = 0; m_flag = 1'b0; e_fs = 1'b1;
          m_len = FRAME_TICKS * (int'(cfg_div) + 1);
          for (int i = 0; i < N_CH; i++) m_active[i] = m_pending[i];
        end
      end else if (m_pos == m_len - 1) begin
        e_ack = m_flag;
        if (m_flag) for (int i = 0; i < N_CH; i++) m_active[i] = m_pending[i];
        m_flag = commit;
        m_pos = 0;
        m_len = FRAME_TICKS * (int'(cfg_div) + 1);
        if (m_mode == 2 && !en) m_mode = 0;
        else begin m_mode = en ? 1 : 2; e_fs = 1'b1; end
      end else begin
        m_pos++;
        m_flag = m_flag | commit;
        m_mode = en ? 1 : 2;
      end
      if (wr_en && int'(wr_ch) < N_CH) m_pending[wr_ch] = int'(wr_val);
      if (e_fs) begin
        for (int i = 0; i < N_CH; i++) hi[i*16 +: 16] = 16'(m_active[i] * (m_len / FRAME_TICKS));
        q_len.push_back(m_len);
        q_hi.push_back(hi);
      end
    end
    q_ctl.push_back({m_mode != 0, e_fs, e_ack, e_werr, m_mode == 0});
  end

  // Control monitor: compares the single-cycle outputs with the model's prediction.
  always @(negedge clk) begin
    logic [4:0] e;
    if (q_ctl.size() > 0) begin
      e = q_ctl.pop_front();
      chk("busy", 64'(busy), 64'(e[4]));
      chk("frame_start", 64'(frame_start), 64'(e[3]));
      chk("commit_ack", 64'(commit_ack), 64'(e[2]));
      chk("wr_err", 64'(wr_err), 64'(e[1]));
      if (e[0]) chk("pwm_idle", 64'(pwm_out), 64'd0);
    end
  end

  int                 t_rel   = 0;
  bit                 mon_in  = 1'b0;
  int                 cur_len = 0;
  logic [N_CH*16-1:0] cur_hi  = '0;

  // Frame monitor: on each frame_start pops the expected frame, then checks pulse shape and length.
  always @(negedge clk) begin
    logic [N_CH-1:0] exp_pwm;
    if (mon_in) t_rel++;
    if (mon_in && (frame_start === 1'b1 || busy !== 1'b1)) begin
      if (m_aborted) m_aborted = 1'b0;
      else chk("frame_len", 64'(t_rel), 64'(cur_len));
      mon_in = 1'b0;
    end
    if (frame_start === 1'b1) begin
      if (q_len.size() == 0) begin
        chk("unexpected_frame_start", 64'd1, 64'd0);
      end else begin
        cur_len = q_len.pop_front();
        cur_hi  = q_hi.pop_front();
        mon_in  = 1'b1;
        t_rel   = 0;
      end
    end
    if (mon_in) begin
      for (int i = 0; i < N_CH; i++)
        exp_pwm[i] = (t_rel >= 1) && (t_rel <= int'(cur_hi[i*16 +: 16]));
      chk("pwm_shape", 64'(pwm_out), 64'(exp_pwm));
      if (t_rel > cur_len + 2) begin
        chk("frame_overrun", 64'(t_rel), 64'(cur_len));
        mon_in = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    wr_en  = 1'b0;
    commit = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write(input int ch, input int val);
    wr_en  = 1'b1;
    wr_ch  = 4'(ch);
    wr_val = 8'(val);
    tick();
  endtask

  // Waits until the model says the next edge is at frame position p.
  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while (!(m_mode != 0 && m_pos == p) && k < 5000) begin
      tick();
      k++;
    end
    if (k >= 5000) chk("wait_pos_timeout", 64'(k), 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_div = 8'd0;
    wr_en = 1'b0; wr_ch = 4'd0; wr_val = 8'd0; commit = 1'b0;
    ticks(3);
    rst = 1'b0;
    tick();

    // 25% on ch0, 0% on ch1, undivided tick.
    write(0, 64);
    write(1, 0);
    cfg_div = 8'd0;
    en = 1'b1;
    ticks(800);

    // Divider of 4, then change it mid-frame: only the next frame shortens.
    en = 1'b0;
    ticks(300);
    cfg_div = 8'd3;
    en = 1'b1;
    tick();
    wait_pos(120);
    cfg_div = 8'd0;
    ticks(1600);

    // Deferred commit: new duty shows only from the next frame.
    commit = 1'b1;
    write(2, 100);
    ticks(300);
    wait_pos(50);
    commit = 1'b1;
    write(2, 200);
    commit = 1'b1;
    tick();
    ticks(600);

    // Commit and write on the boundary cycle itself wait for the following boundary.
    wait_pos(255);
    commit = 1'b1;
    write(0, 30);
    ticks(600);

    // Drain: stop mid-frame, frame completes, then silence.
    wait_pos(10);
    en = 1'b0;
    ticks(300);

    // Out-of-range channel writes are rejected and change nothing.
    en = 1'b1;
    ticks(20);
    write(13, 77);
    write(15, 5);
    commit = 1'b1;
    tick();
    ticks(600);

    // Reset mid-run clears both banks; restart shows all channels low.
    wait_pos(30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ticks(600);

    // Randomised traffic.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        wr_en  = 1'b1;
        wr_ch  = 4'($urandom_range(0, 15));
        wr_val = 8'($urandom);
      end
      if ($urandom_range(0, 199) == 0) commit = 1'b1;
      if ($urandom_range(0, 799) == 0) en = ~en;
      if ($urandom_range(0, 999) == 0) cfg_div = 8'($urandom_range(0, 2));
      tick();
    end

    en = 1'b0;
    ticks(1100);
    chk("frames_left", 64'(q_len.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
